// File: rtl/thermal_drive_guard.sv
// Safety supervisor: debounced, hysteretic over-temperature shutdown plus a
// Moore drive-enable FSM that shutdown forces back to IDLE. All outputs are flops.
module thermal_drive_guard #(
  parameter int N_CH     = 4,
  parameter int TEMP_W   = 8,
  parameter int T_HOT    = 90,
  parameter int T_COOL   = 70,
  parameter int DEB_CYC  = 4,
  parameter int COOL_CYC = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CH*TEMP_W-1:0]   temp,
  input  logic [N_CH-1:0]          temp_valid,
  input  logic                     arrived,
  input  logic                     gas_tank_empty,
  output logic                     shut_off_computer,
  output logic                     keep_driving,
  output logic [N_CH-1:0]          hot_ch,
  output logic [1:0]               drv_state
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CW = $clog2(COOL_CYC + 1);

  localparam logic [TEMP_W-1:0] HOT_TH    = TEMP_W'(T_HOT);
  localparam logic [TEMP_W-1:0] COOL_TH   = TEMP_W'(T_COOL);
  localparam logic [DW-1:0]     DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [CW-1:0]     COOL_LAST = CW'(COOL_CYC - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRIVE    = 2'd1;
  localparam logic [1:0] S_ARRIVED  = 2'd2;
  localparam logic [1:0] S_FUEL_OUT = 2'd3;

  logic [N_CH-1:0] hot_q, hot_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [CW-1:0]   cool_q, cool_d;
  logic            shut_q, shut_d;
  logic [1:0]      state_q, state_d;
  logic            keep_q, keep_d;
  logic            any_hot;

  // Samples strictly between the thresholds, or invalid ones, leave the flag alone.
  always_comb begin
    hot_d = hot_q;
    for (int i = 0; i < N_CH; i++) begin
      if (temp_valid[i]) begin
        if (temp[i*TEMP_W +: TEMP_W] >= HOT_TH)
          hot_d[i] = 1'b1;
        else if (temp[i*TEMP_W +: TEMP_W] <= COOL_TH)
          hot_d[i] = 1'b0;
      end
    end
  end

  assign any_hot = |hot_q;

  // Only one of the two counters runs at a time, selected by the shutdown state.
  always_comb begin
    shut_d = shut_q;
    deb_d  = '0;
    cool_d = '0;
    if (!shut_q) begin
      if (any_hot) begin
        if (deb_q == DEB_LAST)
          shut_d = 1'b1;
        else
          deb_d = deb_q + 1'b1;
      end
    end else begin
      if (!any_hot) begin
        if (cool_q == COOL_LAST)
          shut_d = 1'b0;
        else
          cool_d = cool_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (shut_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (!arrived && !gas_tank_empty) state_d = S_DRIVE;
        S_DRIVE:    if (arrived)             state_d = S_ARRIVED;
                    else if (gas_tank_empty) state_d = S_FUEL_OUT;
        S_ARRIVED:  if (!arrived)        state_d = S_IDLE;
        S_FUEL_OUT: if (!gas_tank_empty) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
    keep_d = (state_d == S_DRIVE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hot_q   <= '0;
      deb_q   <= '0;
      cool_q  <= '0;
      shut_q  <= 1'b0;
      state_q <= S_IDLE;
      keep_q  <= 1'b0;
    end else begin
      hot_q   <= hot_d;
      deb_q   <= deb_d;
      cool_q  <= cool_d;
      shut_q  <= shut_d;
      state_q <= state_d;
      keep_q  <= keep_d;
    end
  end

  assign shut_off_computer = shut_q;
  assign keep_driving      = keep_q;
  assign hot_ch            = hot_q;
  assign drv_state         = state_q;

endmodule
